// File: rtl/relu_maxpool2x2_pkg.sv
// Shared constants for the ReLU + requantize + 2x2 max-pool stage that sits
// after the 3x3 convolution engine.
package pool_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_MAP_W = 26;
  localparam int DEF_MAP_H = 26;
  localparam int DEF_SHIFT = 12;

  localparam int POOL_W = DEF_MAP_W / 2;
  localparam int POOL_H = DEF_MAP_H / 2;

  // Counter width for a range of n values, kept at least one bit wide.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int COL_W = cnt_w(DEF_MAP_W);
  localparam int ROW_W = cnt_w(DEF_MAP_H);
  localparam int LB_AW = cnt_w(POOL_W);

  localparam logic [DEF_OUT_W-1:0] OUT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};

endpackage

// File: rtl/relu_maxpool2x2_if.sv
// Sample stream between the conv engine, this pooling stage and the next layer.
interface relu_maxpool2x2_if
  import pool_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
);
  logic signed [IN_W-1:0]  data_in;
  logic                    in_valid;
  logic        [OUT_W-1:0] data_out;
  logic                    out_valid;
  logic                    frame_done;

  modport master (
    output data_in, in_valid,
    input  data_out, out_valid, frame_done
  );

  modport slave (
    input  data_in, in_valid,
    output data_out, out_valid, frame_done
  );
endinterface

// File: rtl/relu_maxpool2x2_relu_requant.sv
// ReLU followed by an arithmetic right shift and saturation into the
// non-negative half of an OUT_W-bit word.
module relu_requant
  import pool_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic signed [IN_W-1:0]  data_i,
  output logic        [OUT_W-1:0] q_o
);

  localparam logic [IN_W-1:0] SAT = IN_W'((64'd1 << (OUT_W - 1)) - 64'd1);

  logic [IN_W-1:0] shifted;

  always_comb begin
    shifted = IN_W'(data_i >>> SHIFT);
    if (data_i[IN_W-1]) begin
      q_o = '0;
    end else if (shifted > SAT) begin
      q_o = SAT[OUT_W-1:0];
    end else begin
      q_o = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/relu_maxpool2x2.sv
// Raster-order 2x2/stride-2 max-pool over requantized conv results; one
// registered output strobe per completed window.
module relu_maxpool2x2
  import pool_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int MAP_W = DEF_MAP_W,
  parameter int MAP_H = DEF_MAP_H,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic clk,
  input  logic reset_n,
  relu_maxpool2x2_if.slave bus
);

  localparam int PW   = MAP_W / 2;
  localparam int PH   = MAP_H / 2;
  localparam int CW   = cnt_w(MAP_W);
  localparam int RW   = cnt_w(MAP_H);
  localparam int AW   = cnt_w(PW);
  localparam logic [CW-1:0] COL_END  = CW'(MAP_W - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(MAP_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(2 * PW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(2 * PH - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [OUT_W-1:0] hold_q, hold_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             ov_q, ov_d;
  logic             fd_q, fd_d;
  logic [OUT_W-1:0] lbuf_q [PW];

  logic [OUT_W-1:0] q;
  logic [OUT_W-1:0] pm;
  logic [OUT_W-1:0] lb_rd;
  logic [AW-1:0]    lb_idx;
  logic             lb_we;

  relu_requant #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .data_i (bus.data_in),
    .q_o    (q)
  );

  assign lb_idx = AW'(col_q >> 1);
  assign lb_rd  = lbuf_q[lb_idx];
  assign pm     = (q > hold_q) ? q : hold_q;

  // Odd trailing column/row fall through naturally: an even column only
  // loads hold, and an even row only fills the line buffer.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    dout_d = dout_q;
    ov_d   = 1'b0;
    fd_d   = 1'b0;
    lb_we  = 1'b0;
    if (bus.in_valid) begin
      if (col_q == COL_END) begin
        col_d = '0;
        row_d = (row_q == ROW_END) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        hold_d = q;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        dout_d = (lb_rd > pm) ? lb_rd : pm;
        ov_d   = 1'b1;
        fd_d   = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      hold_q <= '0;
      dout_q <= '0;
      ov_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hold_q <= hold_d;
      dout_q <= dout_d;
      ov_q   <= ov_d;
      fd_q   <= fd_d;
    end
  end

  // Every entry is written on an even row before the odd row reads it,
  // so the line buffer needs no reset.
  always_ff @(posedge clk) begin
    if (lb_we) lbuf_q[lb_idx] <= pm;
  end

  assign bus.data_out   = dout_q;
  assign bus.out_valid  = ov_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Scoreboard bench for relu_maxpool2x2: a behavioural model pushes each
// window result as its bottom-right sample is driven; a monitor pops on out_valid.
module tb_relu_maxpool2x2;

  localparam int MW = 26;
  localparam int MH = 26;
  localparam int NWIN = (MW / 2) * (MH / 2);

  typedef struct {
    int d;
    bit f;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  relu_maxpool2x2_if #(.IN_W(32), .OUT_W(16)) bus ();

  relu_maxpool2x2 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  int   out_log[$];
  int   n_out = 0;
  int   n_fd = 0;
  int   tb_r = 0;
  int   tb_c = 0;
  int   tbq [MH][MW];
  bit   prev_ov = 1'b0;

  function automatic int ref_q(input logic signed [31:0] x);
    longint v;
    if (x < 0) return 0;
    v = longint'(x) / 4096;
    if (v > 32767) return 32767;
    return int'(v);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_accept(input logic signed [31:0] x);
    exp_t e;
    tbq[tb_r][tb_c] = ref_q(x);
    if ((tb_r % 2 == 1) && (tb_c % 2 == 1)) begin
      e.d = max2(max2(tbq[tb_r-1][tb_c-1], tbq[tb_r-1][tb_c]),
                 max2(tbq[tb_r][tb_c-1], tbq[tb_r][tb_c]));
      e.f = (tb_r == MH - 1) && (tb_c == MW - 1);
      exp_q.push_back(e);
    end
    if (tb_c == MW - 1) begin
      tb_c = 0;
      tb_r = (tb_r == MH - 1) ? 0 : tb_r + 1;
    end else begin
      tb_c = tb_c + 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.frame_done && !bus.out_valid) begin
      tests++;
      fails++;
      $display("FAIL frame_done_alone: frame_done=1 out_valid=0 required frame_done=0");
    end
    if (bus.out_valid) begin
      tests++;
      if (prev_ov) begin
        fails++;
        $display("FAIL out_valid_width: out_valid high 2 cycles, required 1");
      end
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: data_out=%0d with empty scoreboard", bus.data_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.data_out !== 16'(e.d) || bus.frame_done !== e.f) begin
          fails++;
          $display("FAIL pool_value: got data=%0d fd=%0b required data=%0d fd=%0b",
                   bus.data_out, bus.frame_done, e.d, e.f);
        end
      end
      out_log.push_back(int'(bus.data_out));
      n_out++;
      if (bus.frame_done) n_fd++;
    end
    prev_ov = bus.out_valid;
  end

  task automatic clear_stats();
    n_out = 0;
    n_fd = 0;
    out_log.delete();
  endtask

  task automatic send(input logic signed [31:0] x, input int gap);
    bus.data_in  = x;
    bus.in_valid = 1'b1;
    model_accept(x);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.data_in  = $urandom;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic signed [31:0] sample(input int kind, input int r, input int c);
    case (kind)
      0:       return 32'((r * MW + c) * 4096);
      1:       return -32'sd1000;
      2:       return 32'h7FFF_FFFF;
      3: begin
        case ((r * 7 + c * 3) % 4)
          0:       return 32'h07FF_FFFF;
          1:       return 32'h0800_0000;
          2:       return 32'h07FF_EFFF;
          default: return 32'h0000_0FFF;
        endcase
      end
      default: return 32'($urandom_range(32'h0A00_0000, 0)) - 32'h0100_0000;
    endcase
  endfunction

  task automatic run_frame(input int kind, input bit gapped);
    int g;
    for (int r = 0; r < MH; r++) begin
      for (int c = 0; c < MW; c++) begin
        g = 0;
        if (gapped) g = 1 + (($urandom_range(3, 0) == 0) ? int'($urandom_range(5, 0)) : 0);
        send(sample(kind, r, c), g);
      end
    end
  endtask

  task automatic drain_and_check(input string name, input int want_out, input int want_fd);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d outputs missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tests++;
    if (n_out != want_out) begin
      fails++;
      $display("FAIL %s_count: got %0d outputs required %0d", name, n_out, want_out);
    end
    tests++;
    if (n_fd != want_fd) begin
      fails++;
      $display("FAIL %s_frame_done: got %0d pulses required %0d", name, n_fd, want_fd);
    end
  endtask

  task automatic check_log(input string name, input int idx, input int want);
    tests++;
    if (idx >= out_log.size()) begin
      fails++;
      $display("FAIL %s: output %0d absent, required %0d", name, idx, want);
    end else if (out_log[idx] != want) begin
      fails++;
      $display("FAIL %s: output %0d got %0d required %0d", name, idx, out_log[idx], want);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    reset_n = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.data_out !== 16'd0 || bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: data=%0d ov=%0b fd=%0b required 0/0/0",
               bus.data_out, bus.out_valid, bus.frame_done);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    clear_stats();
    run_frame(0, 1'b0);
    drain_and_check("ramp", NWIN, 1);
    check_log("ramp_first", 0, 27);
    check_log("ramp_last", NWIN - 1, 675);
  endtask

  task automatic test_negative();
    clear_stats();
    run_frame(1, 1'b0);
    drain_and_check("negative", NWIN, 1);
    check_log("negative_first", 0, 0);
  endtask

  task automatic test_saturation();
    clear_stats();
    run_frame(2, 1'b0);
    drain_and_check("saturate_max", NWIN, 1);
    check_log("saturate_max_first", 0, 32767);
    clear_stats();
    run_frame(3, 1'b0);
    drain_and_check("saturate_edge", NWIN, 1);
  endtask

  task automatic test_random();
    clear_stats();
    run_frame(4, 1'b0);
    drain_and_check("random", NWIN, 1);
  endtask

  task automatic test_gapped();
    clear_stats();
    run_frame(0, 1'b1);
    drain_and_check("gapped", NWIN, 1);
    check_log("gapped_first", 0, 27);
    check_log("gapped_last", NWIN - 1, 675);
  endtask

  task automatic test_back_to_back();
    clear_stats();
    run_frame(0, 1'b0);
    run_frame(0, 1'b0);
    drain_and_check("back_to_back", 2 * NWIN, 2);
    check_log("b2b_frame2_first", NWIN, 27);
    check_log("b2b_frame2_last", 2 * NWIN - 1, 675);
  endtask

  task automatic test_reset_mid();
    clear_stats();
    for (int k = 0; k < 100; k++) send(sample(0, k / MW, k % MW), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_pre: %0d outputs missing before reset, required 0", exp_q.size());
      exp_q.delete();
    end
    reset_n = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: data=%0d ov=%0b required 0/0", bus.data_out, bus.out_valid);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tb_r = 0;
    tb_c = 0;
    clear_stats();
    run_frame(0, 1'b0);
    drain_and_check("reset_mid", NWIN, 1);
    check_log("reset_mid_first", 0, 27);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_saturation();
    test_random();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
